// File: rtl/uart_readback_tx_if.sv
// Request and byte-level uart_tx handshake bundle for the readback reply path.
// The master modport is the environment side; the slave modport is the reply engine.
interface uart_readback_tx_if;
    logic       req_valid_i;
    logic [7:0] req_code_i;
    logic       req_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_enable_o;
    logic       tx_busy_i;

    modport master (
        output req_valid_i, req_code_i, tx_busy_i,
        input  req_ready_o, tx_data_o, tx_enable_o
    );

    modport slave (
        input  req_valid_i, req_code_i, tx_busy_i,
        output req_ready_o, tx_data_o, tx_enable_o
    );
endinterface

// File: rtl/uart_readback_tx.sv
// Glitcher readback reply engine: snapshots the configuration on a request and
// streams a framed reply (header, payload MSB-first, XOR checksum) into uart_tx.
module uart_readback_tx #(
    parameter logic [7:0]  VERSION     = 8'h01,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_readback_tx_if.slave       bus,
    input  logic [15:0]             delay_i,
    input  logic [7:0]              width_i,
    input  logic [7:0]              num_pulses_i,
    input  logic [15:0]             pulse_spacing_i,
    input  logic [15:0]             reset_length_i,
    output logic                    err_o
);
    localparam int unsigned BUF_DEPTH = 10;
    localparam int unsigned PAY_MAX   = 8;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned TMO_W     = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t           state;
    logic [7:0]       frame [BUF_DEPTH];
    logic [IDX_W-1:0] len;
    logic [IDX_W-1:0] idx;
    logic [TMO_W-1:0] tmo;

    logic [7:0]       pay [PAY_MAX];
    logic [IDX_W-1:0] pay_len;
    logic             known;
    logic [7:0]       chk;
    logic [7:0]       ld_buf [BUF_DEPTH];
    logic [IDX_W-1:0] ld_len;

    // Frame image built from the live inputs; captured only at the accept edge.
    always_comb begin
        for (int i = 0; i < int'(PAY_MAX); i++) pay[i] = 8'h00;
        for (int i = 0; i < int'(BUF_DEPTH); i++) ld_buf[i] = 8'h00;
        pay_len = '0;
        known   = 1'b1;
        case (bus.req_code_i)
            8'h44: begin
                pay[0] = delay_i[15:8]; pay[1] = delay_i[7:0]; pay_len = IDX_W'(2);
            end
            8'h57: begin pay[0] = width_i;      pay_len = IDX_W'(1); end
            8'h4E: begin pay[0] = num_pulses_i; pay_len = IDX_W'(1); end
            8'h53: begin
                pay[0] = pulse_spacing_i[15:8]; pay[1] = pulse_spacing_i[7:0]; pay_len = IDX_W'(2);
            end
            8'h52: begin
                pay[0] = reset_length_i[15:8]; pay[1] = reset_length_i[7:0]; pay_len = IDX_W'(2);
            end
            8'h41: begin
                pay[0] = delay_i[15:8];         pay[1] = delay_i[7:0];
                pay[2] = width_i;               pay[3] = num_pulses_i;
                pay[4] = pulse_spacing_i[15:8]; pay[5] = pulse_spacing_i[7:0];
                pay[6] = reset_length_i[15:8];  pay[7] = reset_length_i[7:0];
                pay_len = IDX_W'(8);
            end
            8'h56: begin pay[0] = VERSION; pay_len = IDX_W'(1); end
            default: known = 1'b0;
        endcase

        // Unused payload slots are zero, so folding all of them is harmless.
        chk = bus.req_code_i;
        for (int i = 0; i < int'(PAY_MAX); i++) chk = chk ^ pay[i];

        if (known) begin
            ld_buf[0] = bus.req_code_i;
            for (int i = 0; i < int'(PAY_MAX); i++) begin
                if (IDX_W'(i) < pay_len) ld_buf[i+1] = pay[i];
            end
            for (int i = 1; i < int'(BUF_DEPTH); i++) begin
                if (IDX_W'(i) == pay_len + IDX_W'(1)) ld_buf[i] = chk;
            end
            ld_len = pay_len + IDX_W'(2);
        end else begin
            ld_buf[0] = 8'h3F;
            ld_len    = IDX_W'(1);
        end
    end

    // Reply sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.req_ready_o <= 1'b1;
            bus.tx_enable_o <= 1'b0;
            bus.tx_data_o   <= 8'h00;
            err_o           <= 1'b0;
            len             <= '0;
            idx             <= '0;
            tmo             <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) frame[i] <= 8'h00;
        end else begin
            bus.tx_enable_o <= 1'b0;
            err_o           <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        frame           <= ld_buf;
                        len             <= ld_len;
                        idx             <= '0;
                        state           <= SEND;
                        bus.req_ready_o <= 1'b0;
                    end
                end
                SEND: begin
                    if (!bus.tx_busy_i) begin
                        bus.tx_data_o   <= frame[idx];
                        bus.tx_enable_o <= 1'b1;
                        tmo             <= '0;
                        state           <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (bus.tx_busy_i) begin
                        state <= WAIT_LO;
                    end else if (tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
                        err_o           <= 1'b1;
                        state           <= IDLE;
                        bus.req_ready_o <= 1'b1;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                WAIT_LO: begin
                    if (!bus.tx_busy_i) begin
                        if (idx == len - IDX_W'(1)) begin
                            state           <= IDLE;
                            bus.req_ready_o <= 1'b1;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= SEND;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    bus.req_ready_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_readback_tx.sv
// Directed bench for uart_readback_tx with a behavioural uart_tx busy responder.
module tb_uart_readback_tx;
    logic        clk;
    logic        rst_n;
    logic [15:0] delay;
    logic [7:0]  width;
    logic [7:0]  num_pulses;
    logic [15:0] spacing;
    logic [15:0] reset_length;
    logic        err;

    uart_readback_tx_if bus ();

    uart_readback_tx #(.VERSION(8'h01), .ACK_TIMEOUT(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .delay_i         (delay),
        .width_i         (width),
        .num_pulses_i    (num_pulses),
        .pulse_spacing_i (spacing),
        .reset_length_i  (reset_length),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart_tx stand-in: busy rises the edge after an enable and holds for 20 cycles.
    logic       stuck;
    int         busy_cnt;
    int         n_en;
    logic [7:0] cap_q [$];

    initial n_en = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_busy_i <= 1'b0;
            busy_cnt      <= 0;
        end else if (bus.tx_enable_o) begin
            cap_q.push_back(bus.tx_data_o);
            n_en <= n_en + 1;
            if (!stuck) begin
                bus.tx_busy_i <= 1'b1;
                busy_cnt      <= 20;
            end
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) bus.tx_busy_i <= 1'b0;
        end
    end

    int         n_cmp;
    int         n_bad;
    int         cb;
    int         e0;
    int         k;
    logic [7:0] exp_b [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] code);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_code_i  = code;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int target);
        int cyc;
        cyc = 0;
        while (!(bus.req_ready_o && cap_q.size() >= target) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, 32'(cyc < 2000), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input int n);
        chk({tag, "_count"}, 32'(cap_q.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < cap_q.size())
                chk($sformatf("%s_b%0d", tag, i), 32'(cap_q[base+i]), 32'(exp_b[i]));
            else
                chk($sformatf("%s_b%0d", tag, i), 32'hDEAD, 32'(exp_b[i]));
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        stuck = 1'b0;
        bus.req_valid_i = 1'b0; bus.req_code_i = 8'h00;
        delay = 16'h1234; width = 8'hA5; num_pulses = 8'h00;
        spacing = 16'h0000; reset_length = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_enable", 32'(bus.tx_enable_o), 32'd0);
        chk("rst_data", 32'(bus.tx_data_o), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 'D' with first-enable latency check
        cb = cap_q.size(); e0 = n_en;
        send_req(8'h44);
        chk("d_ready_low", 32'(bus.req_ready_o), 32'd0);
        chk("d_en_not_yet", 32'(bus.tx_enable_o), 32'd0);
        @(negedge clk);
        chk("d_en_latency", 32'(bus.tx_enable_o), 32'd1);
        chk("d_first_data", 32'(bus.tx_data_o), 32'h44);
        wait_frame("d", cb + 4);
        exp_b = '{8'h44, 8'h12, 8'h34, 8'h62, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frame("d", cb, 4);
        chk("d_enables", 32'(n_en - e0), 32'd4);
        chk("d_ready_back", 32'(bus.req_ready_o), 32'd1);

        // 'W' with an ignored 'N' issued mid-frame
        cb = cap_q.size(); e0 = n_en;
        send_req(8'h57);
        repeat (5) @(negedge clk);
        chk("w_busy_ready", 32'(bus.req_ready_o), 32'd0);
        send_req(8'h4E);
        wait_frame("w", cb + 3);
        repeat (40) @(negedge clk);
        exp_b = '{8'h57, 8'hA5, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frame("w", cb, 3);
        chk("w_enables", 32'(n_en - e0), 32'd3);
        chk("w_idle_ready", 32'(bus.req_ready_o), 32'd1);

        // 'A' snapshot; inputs change right after accept
        delay = 16'h0102; width = 8'h03; num_pulses = 8'h04;
        spacing = 16'h0506; reset_length = 16'h0708;
        cb = cap_q.size(); e0 = n_en;
        send_req(8'h41);
        delay = 16'hFFFF; width = 8'hEE; num_pulses = 8'hDD;
        spacing = 16'hCCCC; reset_length = 16'hBBBB;
        wait_frame("a", cb + 10);
        exp_b = '{8'h41, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h49};
        check_frame("a", cb, 10);
        chk("a_enables", 32'(n_en - e0), 32'd10);

        // unknown code, then version
        cb = cap_q.size();
        send_req(8'h7A);
        wait_frame("unk", cb + 1);
        repeat (3) @(negedge clk);
        exp_b = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frame("unk", cb, 1);
        cb = cap_q.size();
        send_req(8'h56);
        wait_frame("ver", cb + 3);
        exp_b = '{8'h56, 8'h01, 8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frame("ver", cb, 3);

        // handshake timeout: busy never rises
        stuck = 1'b1;
        e0 = n_en;
        send_req(8'h57);
        @(negedge clk);
        chk("tmo_enable", 32'(bus.tx_enable_o), 32'd1);
        repeat (7) @(negedge clk);
        chk("tmo_err_early", 32'(err), 32'd0);
        @(negedge clk);
        chk("tmo_err_pulse", 32'(err), 32'd1);
        chk("tmo_ready", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        chk("tmo_err_drop", 32'(err), 32'd0);
        repeat (30) @(negedge clk);
        chk("tmo_enables", 32'(n_en - e0), 32'd1);
        stuck = 1'b0;

        // async reset while the second byte of 'A' is being launched
        cb = cap_q.size();
        send_req(8'h41);
        k = 0;
        while (!(bus.tx_enable_o && cap_q.size() == cb + 1) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_found", 32'(k < 500), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_enable", 32'(bus.tx_enable_o), 32'd0);
        chk("rst_mid_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_mid_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        width = 8'hA5;
        repeat (2) @(negedge clk);
        cb = cap_q.size(); e0 = n_en;
        send_req(8'h57);
        wait_frame("post", cb + 3);
        exp_b = '{8'h57, 8'hA5, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frame("post", cb, 3);
        chk("post_enables", 32'(n_en - e0), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
